cnn_conv_scheduler: RTL and testbench

Layer-level controller for the CNN line/window buffer. Accepts one convolution-layer descriptor, drives the buffer's configuration and `req`/`req_final` controls once per input channel, and gates window delivery to the downstream MAC array with a valid/ready handshake. It counts delivered windows against the expected count, flags mismatches, and signals layer completion. It sits between the layer-control CSR logic and the buffer/MAC datapath.

---
 rtl/cnn_conv_scheduler.sv | 162 ++++++++++++++++
 tb/tb_cnn_conv_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cnn_conv_scheduler
// Purpose  : Layer controller that issues buffer req/req_final per input channel
//            and gates window delivery to the MAC array.
// Revision : 1.0
// ============================================================================
module cnn_conv_scheduler #(
   parameter int KERNEL_WIDTH = 4,
   parameter int BUFFER_WIDTH = 64,
   parameter int BUFFER_DEPTH = 64,
   parameter int CH_W         = 6,
   parameter int CNT_W        = $clog2(BUFFER_WIDTH*BUFFER_DEPTH)+1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            cfg_valid_i,
   output logic                            cfg_ready_o,
   input  logic [KERNEL_WIDTH-1:0]         cfg_kernel_w_i,
   input  logic [KERNEL_WIDTH-1:0]         cfg_kernel_h_i,
   input  logic [$clog2(BUFFER_WIDTH)-1:0] cfg_width_i,
   input  logic [$clog2(BUFFER_DEPTH)-1:0] cfg_depth_i,
   input  logic [CH_W-1:0]                 cfg_channels_i,
   input  logic                            abort_i,
   output logic [KERNEL_WIDTH-1:0]         buf_kernel_width_o,
   output logic [KERNEL_WIDTH-1:0]         buf_kernel_height_o,
   output logic [$clog2(BUFFER_WIDTH)-1:0] buf_width_o,
   output logic [$clog2(BUFFER_DEPTH)-1:0] buf_depth_o,
   output logic                            buf_req_o,
   output logic                            buf_req_final_o,
   input  logic                            buf_window_valid_i,
   input  logic                            buf_window_finish_i,
   output logic                            buf_window_stall_o,
   output logic                            mac_valid_o,
   input  logic                            mac_ready_i,
   output logic                            mac_last_window_o,
   output logic                            mac_last_channel_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o,
   output logic                            cfg_err_o
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CALC  = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_FINAL = 3'd4;
   localparam logic [2:0] ST_NEXT  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   logic [2:0]                      state_q, state_d;
   logic [KERNEL_WIDTH-1:0]         kw_q, kh_q;
   logic [$clog2(BUFFER_WIDTH)-1:0] width_q;
   logic [$clog2(BUFFER_DEPTH)-1:0] depth_q;
   logic [CH_W-1:0]                 ch_lim_q, ch_idx_q;
   logic [CNT_W-1:0]                expected_q, wcnt_q;
   logic                            hang_q, abort_q, err_q, cfg_err_q;

   logic [31:0]      w_kw_ext, w_kh_ext, w_wlim, w_dlim;
   logic             w_cfg_hs, w_cfg_bad, w_run, w_full, w_hs;
   logic             w_over, w_early_fin, w_exit, w_last_ch, w_abort_take;
   logic [CNT_W-1:0] w_cols, w_rows;

   // Legality compares run at 32 bits so kernel and image widths never truncate.
   assign w_kw_ext  = 32'(cfg_kernel_w_i);
   assign w_kh_ext  = 32'(cfg_kernel_h_i);
   assign w_wlim    = 32'(cfg_width_i) + 32'd1;
   assign w_dlim    = 32'(cfg_depth_i) + 32'd1;
   assign w_cfg_bad = (cfg_kernel_w_i == '0) || (cfg_kernel_h_i == '0) ||
                      (cfg_channels_i == '0) || (w_kw_ext > w_wlim) || (w_kh_ext > w_dlim);
   assign w_cfg_hs  = cfg_valid_i && (state_q == ST_IDLE);

   assign w_cols = CNT_W'(width_q) + CNT_W'(2) - CNT_W'(kw_q);
   assign w_rows = CNT_W'(depth_q) + CNT_W'(2) - CNT_W'(kh_q);

   assign w_run        = (state_q == ST_RUN);
   assign w_full       = (wcnt_q == expected_q);
   assign w_hs         = mac_valid_o && mac_ready_i;
   assign w_over       = w_run && buf_window_valid_i && w_full;
   assign w_early_fin  = w_run && buf_window_finish_i && (wcnt_q < expected_q);
   assign w_exit       = w_run && buf_window_finish_i && w_full && !hang_q;
   assign w_last_ch    = (ch_idx_q == ch_lim_q - CH_W'(1));
   assign w_abort_take = abort_i && ((state_q == ST_CALC) || (state_q == ST_START) ||
                                     (state_q == ST_RUN)  || (state_q == ST_NEXT));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (w_cfg_hs && !w_cfg_bad) state_d = ST_CALC;
         ST_CALC:  state_d = ST_START;
         ST_START: state_d = ST_RUN;
         ST_RUN:   if (w_exit) state_d = ST_FINAL;
         ST_FINAL: state_d = abort_q ? ST_IDLE : ST_NEXT;
         ST_NEXT:  state_d = w_last_ch ? ST_DONE : ST_START;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (w_abort_take) state_d = ST_FINAL;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         kw_q       <= '0;
         kh_q       <= '0;
         width_q    <= '0;
         depth_q    <= '0;
         ch_lim_q   <= '0;
         ch_idx_q   <= '0;
         expected_q <= '0;
         wcnt_q     <= '0;
         hang_q     <= 1'b0;
         abort_q    <= 1'b0;
         err_q      <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= w_cfg_hs && w_cfg_bad;
         if (w_cfg_hs && !w_cfg_bad) begin
            kw_q     <= cfg_kernel_w_i;
            kh_q     <= cfg_kernel_h_i;
            width_q  <= cfg_width_i;
            depth_q  <= cfg_depth_i;
            ch_lim_q <= cfg_channels_i;
            ch_idx_q <= '0;
            err_q    <= 1'b0;
         end
         if (state_q == ST_CALC) expected_q <= w_cols * w_rows;
         if (state_q == ST_START) begin
            wcnt_q <= '0;
            hang_q <= 1'b0;
         end else if (w_hs) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
         end
         // An early finish locks the channel in RUN until abort.
         if (w_early_fin) hang_q <= 1'b1;
         if (w_over || w_early_fin) err_q <= 1'b1;
         if ((state_q == ST_NEXT) && !w_last_ch && !w_abort_take) ch_idx_q <= ch_idx_q + CH_W'(1);
         if (w_abort_take) abort_q <= 1'b1;
         else if (state_q == ST_FINAL) abort_q <= 1'b0;
      end
   end

   assign cfg_ready_o         = (state_q == ST_IDLE);
   assign busy_o              = (state_q != ST_IDLE);
   assign buf_req_o           = (state_q == ST_START);
   assign buf_req_final_o     = (state_q == ST_FINAL);
   assign done_o              = (state_q == ST_DONE);
   assign err_o               = err_q;
   assign cfg_err_o           = cfg_err_q;
   assign buf_kernel_width_o  = kw_q;
   assign buf_kernel_height_o = kh_q;
   assign buf_width_o         = width_q;
   assign buf_depth_o         = depth_q;
   assign mac_valid_o         = w_run && buf_window_valid_i && !w_full;
   assign buf_window_stall_o  = w_run ? !mac_ready_i : 1'b1;
   assign mac_last_window_o   = mac_valid_o && (wcnt_q == expected_q - CNT_W'(1));
   assign mac_last_channel_o  = mac_valid_o && w_last_ch;

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_conv_scheduler
// Purpose  : Self-checking bench; acts as buffer and MAC around the scheduler.
// Revision : 1.0
// ============================================================================
module tb_cnn_conv_scheduler;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       cfg_valid_i = 1'b0;
   logic       cfg_ready_o;
   logic [3:0] cfg_kernel_w_i = '0, cfg_kernel_h_i = '0;
   logic [5:0] cfg_width_i = '0, cfg_depth_i = '0, cfg_channels_i = '0;
   logic       abort_i = 1'b0;
   logic [3:0] buf_kernel_width_o, buf_kernel_height_o;
   logic [5:0] buf_width_o, buf_depth_o;
   logic       buf_req_o, buf_req_final_o;
   logic       buf_window_valid_i = 1'b0, buf_window_finish_i = 1'b0;
   logic       buf_window_stall_o, mac_valid_o, mac_ready_i = 1'b0;
   logic       mac_last_window_o, mac_last_channel_o;
   logic       busy_o, done_o, err_o, cfg_err_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   int st_req, st_fin, st_done, st_hs, st_lastw, st_lastc, st_tmis, st_timeout, st_idle_after, st_cfg_rdy;
   int st_chhs[8];

   cnn_conv_scheduler dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_kernel_w_i(cfg_kernel_w_i), .cfg_kernel_h_i(cfg_kernel_h_i),
      .cfg_width_i(cfg_width_i), .cfg_depth_i(cfg_depth_i), .cfg_channels_i(cfg_channels_i),
      .abort_i(abort_i),
      .buf_kernel_width_o(buf_kernel_width_o), .buf_kernel_height_o(buf_kernel_height_o),
      .buf_width_o(buf_width_o), .buf_depth_o(buf_depth_o),
      .buf_req_o(buf_req_o), .buf_req_final_o(buf_req_final_o),
      .buf_window_valid_i(buf_window_valid_i), .buf_window_finish_i(buf_window_finish_i),
      .buf_window_stall_o(buf_window_stall_o),
      .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i),
      .mac_last_window_o(mac_last_window_o), .mac_last_channel_o(mac_last_channel_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Presents one descriptor for one cycle; returns the handshake cycle number.
   task automatic send_cfg(input int kw, input int kh, input int w, input int d, input int ch, output int t_cfg);
      @(negedge clk_i);
      cfg_valid_i    = 1'b1;
      cfg_kernel_w_i = 4'(kw);
      cfg_kernel_h_i = 4'(kh);
      cfg_width_i    = 6'(w);
      cfg_depth_i    = 6'(d);
      cfg_channels_i = 6'(ch);
      t_cfg          = cyc;
      #1;
      st_cfg_rdy = int'(cfg_ready_o);
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
   endtask

   task automatic wait_req(output int got);
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         @(negedge clk_i);
         #1;
         if (buf_req_o) got = 1;
      end
   endtask

   // Buffer/MAC model for one full layer; collects statistics into st_*.
   // rmode: 0 ready always, 1 ready one cycle in three, 2 random ready.
   task automatic drive_layer(input int kw, input int kh, input int w, input int d, input int ch, input int rmode);
      int exp_win, sent, chn, t_cfg, t_req_exp, t_fin_exp, t_done_exp, budget;
      bit active, in_run, start_next, fin_pend, finished;
      exp_win = (w + 2 - kw) * (d + 2 - kh);
      st_req = 0; st_fin = 0; st_done = 0; st_hs = 0; st_lastw = 0; st_lastc = 0;
      st_tmis = 0; st_timeout = 0; st_idle_after = 0;
      foreach (st_chhs[i]) st_chhs[i] = 0;
      send_cfg(kw, kh, w, d, ch, t_cfg);
      t_req_exp = t_cfg + 2; t_fin_exp = -1; t_done_exp = -1;
      active = 0; in_run = 0; start_next = 0; fin_pend = 0; finished = 0;
      sent = 0; chn = -1; budget = 0;
      while (!finished && budget < 20000) begin
         @(negedge clk_i);
         budget++;
         if (start_next) begin
            active = 1; in_run = 1; sent = 0; chn++; fin_pend = 0; start_next = 0;
         end
         buf_window_finish_i = 1'b0;
         if (active && sent == exp_win && !fin_pend) begin
            buf_window_finish_i = 1'b1;
            fin_pend  = 1;
            active    = 0;
            t_fin_exp = cyc + 1;
         end
         buf_window_valid_i = active && (sent < exp_win) && ($urandom_range(3) != 0);
         case (rmode)
            0:       mac_ready_i = 1'b1;
            1:       mac_ready_i = (cyc % 3 == 0);
            default: mac_ready_i = 1'($urandom_range(1));
         endcase
         #1;
         if (buf_req_o) begin
            st_req++;
            if (cyc != t_req_exp) st_tmis++;
            start_next = 1;
         end
         if (buf_req_final_o) begin
            st_fin++;
            if (cyc != t_fin_exp) st_tmis++;
            in_run = 0;
            t_req_exp = cyc + 2;
            t_done_exp = cyc + 2;
         end
         if (done_o) begin
            st_done++;
            if (cyc != t_done_exp || chn != ch - 1) st_tmis++;
            finished = 1;
         end
         if (in_run) begin
            if (mac_valid_o !== buf_window_valid_i) st_tmis++;
            if (buf_window_stall_o !== !mac_ready_i) st_tmis++;
         end
         if (mac_valid_o && mac_ready_i) begin
            sent++;
            st_hs++;
            if (chn >= 0 && chn < 8) st_chhs[chn]++;
            if (mac_last_window_o) begin
               st_lastw++;
               if (sent != exp_win) st_tmis++;
            end else if (sent == exp_win) st_tmis++;
            if (mac_last_channel_o) begin
               st_lastc++;
               if (chn != ch - 1) st_tmis++;
            end else if (chn == ch - 1) st_tmis++;
         end
      end
      if (!finished) st_timeout = 1;
      buf_window_valid_i = 1'b0;
      buf_window_finish_i = 1'b0;
      @(negedge clk_i);
      #1;
      st_idle_after = int'(cfg_ready_o && !busy_o);
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      buf_window_valid_i = 1'b1;
      mac_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      #1;
      n_checks++; if (cfg_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      n_checks++; if (buf_window_stall_o !== 1'b1) begin n_errors++; $display("FAIL reset_stall: got %b expected 1", buf_window_stall_o); end
      n_checks++; if ({buf_req_o, buf_req_final_o, mac_valid_o, done_o, err_o, cfg_err_o} !== 6'b0) begin n_errors++; $display("FAIL reset_pulses: got %b expected 000000", {buf_req_o, buf_req_final_o, mac_valid_o, done_o, err_o, cfg_err_o}); end
      n_checks++; if ({buf_kernel_width_o, buf_kernel_height_o, buf_width_o, buf_depth_o} !== 20'h0) begin n_errors++; $display("FAIL reset_bufcfg: got %h expected 0", {buf_kernel_width_o, buf_kernel_height_o, buf_width_o, buf_depth_o}); end
      buf_window_valid_i = 1'b0;
      mac_ready_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      #1;
      n_checks++; if (cfg_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1 0", cfg_ready_o, busy_o); end
   endtask

   task automatic test_basic;
      drive_layer(3, 3, 7, 7, 2, 0);
      n_checks++; if (st_timeout !== 0) begin n_errors++; $display("FAIL basic_timeout: got %0d expected 0", st_timeout); end
      n_checks++; if (st_cfg_rdy !== 1) begin n_errors++; $display("FAIL basic_cfg_ready: got %0d expected 1", st_cfg_rdy); end
      n_checks++; if (st_req !== 2) begin n_errors++; $display("FAIL basic_req: got %0d expected 2", st_req); end
      n_checks++; if (st_fin !== 2) begin n_errors++; $display("FAIL basic_req_final: got %0d expected 2", st_fin); end
      n_checks++; if (st_done !== 1) begin n_errors++; $display("FAIL basic_done: got %0d expected 1", st_done); end
      n_checks++; if (st_chhs[0] !== 36 || st_chhs[1] !== 36) begin n_errors++; $display("FAIL basic_windows: got %0d,%0d expected 36,36", st_chhs[0], st_chhs[1]); end
      n_checks++; if (st_lastw !== 2) begin n_errors++; $display("FAIL basic_last_window: got %0d expected 2", st_lastw); end
      n_checks++; if (st_lastc !== 36) begin n_errors++; $display("FAIL basic_last_channel: got %0d expected 36", st_lastc); end
      n_checks++; if (st_tmis !== 0) begin n_errors++; $display("FAIL basic_timing: got %0d deviations expected 0", st_tmis); end
      n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b expected 0", err_o); end
      n_checks++; if (st_idle_after !== 1) begin n_errors++; $display("FAIL basic_idle_after: got %0d expected 1", st_idle_after); end
      n_checks++; if ({buf_kernel_width_o, buf_kernel_height_o, buf_width_o, buf_depth_o} !== {4'd3, 4'd3, 6'd7, 6'd7}) begin n_errors++; $display("FAIL basic_bufcfg: got %h expected %h", {buf_kernel_width_o, buf_kernel_height_o, buf_width_o, buf_depth_o}, {4'd3, 4'd3, 6'd7, 6'd7}); end
   endtask

   task automatic test_backpressure;
      drive_layer(3, 3, 7, 7, 2, 1);
      n_checks++; if (st_timeout !== 0 || st_done !== 1) begin n_errors++; $display("FAIL bp_done: got timeout=%0d done=%0d expected 0 1", st_timeout, st_done); end
      n_checks++; if (st_chhs[0] !== 36 || st_chhs[1] !== 36) begin n_errors++; $display("FAIL bp_windows: got %0d,%0d expected 36,36", st_chhs[0], st_chhs[1]); end
      n_checks++; if (st_tmis !== 0) begin n_errors++; $display("FAIL bp_stall_timing: got %0d deviations expected 0", st_tmis); end
   endtask

   task automatic test_illegal(input int kw, input int w);
      int t, reqs, errs;
      send_cfg(kw, 3, w, 7, 1, t);
      #1;
      n_checks++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin n_errors++; $display("FAIL illegal_kw%0d_pulse: got cfg_err=%b busy=%b expected 1 0", kw, cfg_err_o, busy_o); end
      reqs = 0; errs = 0;
      repeat (6) begin
         @(negedge clk_i);
         #1;
         reqs += int'(buf_req_o);
         errs += int'(cfg_err_o) + int'(busy_o);
      end
      n_checks++; if (reqs !== 0 || errs !== 0) begin n_errors++; $display("FAIL illegal_kw%0d_idle: got req=%0d cfg_err/busy=%0d expected 0 0", kw, reqs, errs); end
   endtask

   task automatic test_underflow;
      int t, got, hs, fins, dones;
      send_cfg(3, 3, 7, 7, 1, t);
      wait_req(got);
      n_checks++; if (got !== 1) begin n_errors++; $display("FAIL under_req: got %0d expected 1", got); end
      hs = 0;
      for (int i = 0; i < 60 && hs < 30; i++) begin
         @(negedge clk_i);
         buf_window_valid_i = 1'b1; mac_ready_i = 1'b1;
         #1;
         if (mac_valid_o && mac_ready_i) hs++;
      end
      @(negedge clk_i);
      buf_window_valid_i = 1'b0; buf_window_finish_i = 1'b1;
      @(negedge clk_i);
      buf_window_finish_i = 1'b0;
      fins = 0; dones = 0;
      #1;
      n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL under_err: got %b expected 1", err_o); end
      repeat (5) begin
         @(negedge clk_i);
         #1;
         fins += int'(buf_req_final_o); dones += int'(done_o);
      end
      n_checks++; if (fins !== 0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL under_stuck: got req_final=%0d busy=%b expected 0 1", fins, busy_o); end
      @(negedge clk_i);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      #1;
      n_checks++; if (buf_req_final_o !== 1'b1) begin n_errors++; $display("FAIL abort_final: got %b expected 1", buf_req_final_o); end
      dones += int'(done_o);
      repeat (4) begin
         @(negedge clk_i);
         #1;
         dones += int'(done_o);
      end
      n_checks++; if (busy_o !== 1'b0 || cfg_ready_o !== 1'b1 || dones !== 0) begin n_errors++; $display("FAIL abort_idle: got busy=%b ready=%b done=%0d expected 0 1 0", busy_o, cfg_ready_o, dones); end
   endtask

   task automatic test_overflow;
      int t, got, hs, dones;
      send_cfg(3, 3, 7, 7, 1, t);
      wait_req(got);
      hs = 0;
      for (int i = 0; i < 80 && hs < 36; i++) begin
         @(negedge clk_i);
         buf_window_valid_i = 1'b1; mac_ready_i = 1'b1;
         #1;
         if (mac_valid_o && mac_ready_i) hs++;
      end
      n_checks++; if (hs !== 36) begin n_errors++; $display("FAIL over_windows: got %0d expected 36", hs); end
      @(negedge clk_i);
      #1;
      n_checks++; if (mac_valid_o !== 1'b0) begin n_errors++; $display("FAIL over_forwarded: got mac_valid=%b expected 0", mac_valid_o); end
      @(negedge clk_i);
      buf_window_valid_i = 1'b0;
      #1;
      n_checks++; if (err_o !== 1'b1) begin n_errors++; $display("FAIL over_err: got %b expected 1", err_o); end
      buf_window_finish_i = 1'b1;
      @(negedge clk_i);
      buf_window_finish_i = 1'b0;
      dones = 0;
      repeat (6) begin
         @(negedge clk_i);
         #1;
         dones += int'(done_o);
      end
      n_checks++; if (dones !== 1) begin n_errors++; $display("FAIL over_done: got %0d expected 1", dones); end
   endtask

   task automatic test_degenerate;
      drive_layer(1, 1, 0, 0, 1, 0);
      n_checks++; if (st_timeout !== 0 || st_done !== 1) begin n_errors++; $display("FAIL degen_done: got timeout=%0d done=%0d expected 0 1", st_timeout, st_done); end
      n_checks++; if (st_hs !== 1 || st_lastw !== 1 || st_lastc !== 1) begin n_errors++; $display("FAIL degen_window: got hs=%0d lastw=%0d lastc=%0d expected 1 1 1", st_hs, st_lastw, st_lastc); end
      n_checks++; if (st_tmis !== 0 || err_o !== 1'b0) begin n_errors++; $display("FAIL degen_timing: got dev=%0d err=%b expected 0 0", st_tmis, err_o); end
   endtask

   task automatic test_random;
      int kw, kh, w, d, ch, exp_win;
      for (int it = 0; it < 4; it++) begin
         kw = $urandom_range(4, 1);
         kh = $urandom_range(4, 1);
         w  = $urandom_range(9, kw - 1);
         d  = $urandom_range(9, kh - 1);
         ch = $urandom_range(3, 1);
         exp_win = (w + 2 - kw) * (d + 2 - kh);
         drive_layer(kw, kh, w, d, ch, 2);
         n_checks++; if (st_timeout !== 0 || st_done !== 1 || st_req !== ch || st_fin !== ch) begin n_errors++; $display("FAIL rand%0d_flow: got to=%0d done=%0d req=%0d fin=%0d expected 0 1 %0d %0d", it, st_timeout, st_done, st_req, st_fin, ch, ch); end
         n_checks++; if (st_hs !== ch * exp_win || st_lastw !== ch || st_lastc !== exp_win) begin n_errors++; $display("FAIL rand%0d_windows: got hs=%0d lastw=%0d lastc=%0d expected %0d %0d %0d", it, st_hs, st_lastw, st_lastc, ch * exp_win, ch, exp_win); end
         n_checks++; if (st_tmis !== 0 || err_o !== 1'b0) begin n_errors++; $display("FAIL rand%0d_timing: got dev=%0d err=%b expected 0 0", it, st_tmis, err_o); end
      end
   endtask

   task automatic test_reset_midrun;
      int t, got, hs;
      send_cfg(3, 3, 7, 7, 2, t);
      wait_req(got);
      hs = 0;
      for (int i = 0; i < 30 && hs < 10; i++) begin
         @(negedge clk_i);
         buf_window_valid_i = 1'b1; mac_ready_i = 1'b1;
         #1;
         if (mac_valid_o && mac_ready_i) hs++;
      end
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      n_checks++; if (busy_o !== 1'b0 || cfg_ready_o !== 1'b1 || buf_window_stall_o !== 1'b1) begin n_errors++; $display("FAIL midrst_state: got busy=%b ready=%b stall=%b expected 0 1 1", busy_o, cfg_ready_o, buf_window_stall_o); end
      n_checks++; if ({buf_req_o, buf_req_final_o, mac_valid_o, done_o, buf_kernel_width_o} !== 8'h0) begin n_errors++; $display("FAIL midrst_outputs: got %h expected 0", {buf_req_o, buf_req_final_o, mac_valid_o, done_o, buf_kernel_width_o}); end
      buf_window_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive_layer(2, 2, 5, 3, 1, 2);
      n_checks++; if (st_timeout !== 0 || st_done !== 1 || st_hs !== 15) begin n_errors++; $display("FAIL rerun: got to=%0d done=%0d hs=%0d expected 0 1 15", st_timeout, st_done, st_hs); end
      n_checks++; if (st_tmis !== 0 || err_o !== 1'b0) begin n_errors++; $display("FAIL rerun_timing: got dev=%0d err=%b expected 0 0", st_tmis, err_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_illegal(9, 7);
      test_illegal(0, 7);
      test_underflow();
      test_overflow();
      test_degenerate();
      test_random();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
